shot_resolver: RTL and testbench
================================

Name: shot_resolver

Overview:
Target-side partner of the trigger/firing FSM. It consumes the 2-bit firing state and runs the zapper flash sequence: a black frame, then a white target frame. It samples the light sensor, decides hit or miss, and tracks shells per duck round. It drives `leave` to clear the firing FSM when the round ends: on a hit, when shells run out, or when the duck escapes.

Parameters:
SHELLS, 3, shells per duck round (1..7)
FLASH_CYCLES, 16, clk cycles per flash frame (blank and target each)
SETTLE_CYCLES, 4, initial target-frame cycles in which light_sense is ignored (< FLASH_CYCLES)
ESCAPE_CYCLES, 1024, cumulative ARMED cycles before the duck escapes

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
round_start  in  1  one-cycle pulse; starts a duck round (honoured in IDLE only)
fire_state  in  2  firing FSM state: 00 reload, 01 hold, 11 shot
light_sense  in  1  zapper photodiode, asynchronous to clk
blank_screen  out  1  force the display black
draw_target  out  1  draw a white box at the duck position
hit  out  1  one-cycle pulse, duck hit
miss  out  1  one-cycle pulse, shot missed or duck escaped
escaped  out  1  one-cycle pulse, coincident with miss on timeout
cheat  out  1  one-cycle pulse, light seen during the blank frame (see Optional Feature)
shells_left  out  3  shells remaining in the current round
leave  out  1  one-cycle pulse; clears the firing FSM
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; shells_left 0; escape counter 0; light synchroniser cleared.
- light_sense passes through a 2-FF synchroniser. All decisions use the synchronised value `ls`.
- States:
  - IDLE: on round_start, load shells_left=SHELLS and escape counter=0, then go to ARMED.
  - ARMED: escape counter increments each cycle.
    - On fire_state==11 (sampled at the edge), go to BLANK; the counter holds.
    - If the counter reaches ESCAPE_CYCLES-1 with no shot, go to RESOLVE as an escape.
    - A shot on the expiry cycle takes priority over the escape.
  - BLANK: blank_screen=1 for exactly FLASH_CYCLES cycles. Record bl = OR of `ls` over the last cycle of BLANK. Then go to TARGET.
  - TARGET: draw_target=1 for exactly FLASH_CYCLES cycles. Record tl = OR of `ls` over target cycles SETTLE_CYCLES..FLASH_CYCLES-1. Then go to RESOLVE.
  - RESOLVE (1 cycle). Registered pulse outputs and the shells_left update land on the edge entering RESOLVE:
    - Escape: miss=1, escaped=1; next state LEAVE.
    - Otherwise, decrement shells_left. Result is hit=1 if tl && !cheat_block, else miss=1.
    - After a hit, or when shells_left reaches 0, next state is LEAVE; otherwise ARMED (escape counter resumes, not reset).
  - LEAVE: leave=1 for one cycle, then IDLE.
- Latency: shot sampled at edge N gives blank_screen high at N+1..N+F, draw_target high at N+F+1..N+2F, and hit/miss at N+2F+1 (F=FLASH_CYCLES).
- Ignored inputs:
  - fire_state==11 outside ARMED (the firing FSM self-returns to reload).
  - round_start outside IDLE.
  - fire_state 01/00/10 in all states.
- shells_left never underflows; it is never decremented at 0.
- blank_screen and draw_target are never high together.
- A reset mid-sequence drops both drive outputs the same cycle and produces no leave pulse.

Optional Feature:
SHOT_RESOLVER_CHEAT_DETECT_EN
- Defined: if bl=1, cheat pulses in RESOLVE and cheat_block forces a miss; shells are still consumed.
- Undefined: bl is ignored, cheat is tied 0, and the BLANK frame timing is unchanged.

Decomposition:
- Package shot_pkg holds:
  - firing state constants FIRE_RELOAD=2'b00, FIRE_HOLD=2'b01, FIRE_SHOT=2'b11, shared with the firing FSM;
  - the resolver state enum (IDLE, ARMED, BLANK, TARGET, RESOLVE, LEAVE).
- One sub-module, sync_2ff, provides the light_sense synchroniser and is reusable for other button/sensor inputs.

Test Plan:
Settings used: SHELLS=3, FLASH_CYCLES=8, SETTLE_CYCLES=2, ESCAPE_CYCLES=64.
- Hit: round_start, then shot at N, light_sense high during draw_target cycles 4..7 → hit at N+17, shells_left 3→2, leave at N+18, busy low at N+19.
- Three misses: no light on three shots → miss on each; shells_left 2,1,0; leave only after the third; a fourth shot produces no response.
- Escape: round_start with no shot → after 64 ARMED cycles, miss=escaped=1 in the same cycle, shells_left stays 3, then leave.
- Settle window: light only in target cycles 0..1 → miss.
- Cheat, with the macro defined: light held high throughout → cheat=1, miss=1, hit=0. Without the macro: hit=1, cheat=0.
- Async reset asserted mid-TARGET → draw_target=0 immediately, all outputs 0, no leave pulse; a subsequent round_start restores shells_left=3.

Source files
------------

// File: rtl/shot_pkg.sv
// -----------------------------------------------------------------------------
// shot_pkg
//
// Shared definitions for the zapper target side.
//   - Firing FSM state encodings. The firing FSM and the shot resolver import
//     the same constants so their 2-bit interface cannot drift apart.
//   - Resolver state enum. The numeric values are also what appears on the
//     resolver's dbg_state output.
// -----------------------------------------------------------------------------
package shot_pkg;

    // Firing FSM state as seen on fire_state. 2'b10 is unused and ignored.
    localparam logic [1:0] FIRE_RELOAD = 2'b00;
    localparam logic [1:0] FIRE_HOLD   = 2'b01;
    localparam logic [1:0] FIRE_SHOT   = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        BLANK   = 3'd2,
        TARGET  = 3'd3,
        RESOLVE = 3'd4,
        LEAVE   = 3'd5
    } shot_state_t;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchroniser for slow asynchronous inputs such as buttons and
// sensors. It adds two clk cycles of latency. It is not suitable for buses
// whose bits must arrive together.
//
// Parameters:
//   WIDTH    number of independent single-bit inputs
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous, active-low reset; clears both stages
//   i_d      in   WIDTH  asynchronous input
//   o_q      out  WIDTH  synchronised output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/shot_resolver.sv
// -----------------------------------------------------------------------------
// shot_resolver
//
// Target-side partner of the trigger/firing FSM. When a shot is seen it runs
// the zapper flash sequence: one black frame, then one frame with a white box
// at the duck. It samples the photodiode to decide hit or miss, and it tracks
// the shells left in the duck round. When the round ends (a hit, no shells
// left, or the duck escapes) it pulses leave to clear the firing FSM.
//
// Optional feature (compile-time macro SHOT_RESOLVER_CHEAT_DETECT_EN):
//   Defined   - light seen on the last blank-frame cycle pulses cheat and
//               forces a miss. The shell is still consumed.
//   Undefined - blank-frame light is ignored and cheat stays 0. Frame timing
//               is the same in both builds.
//
// Parameters:
//   SHELLS         shells per duck round (1..7)
//   FLASH_CYCLES   clk cycles per flash frame (blank and target each)
//   SETTLE_CYCLES  first target-frame cycles in which light is ignored
//   ESCAPE_CYCLES  cumulative ARMED cycles before the duck escapes
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   round_start   in   1-cycle pulse; starts a duck round (IDLE only)
//   fire_state    in   2  firing FSM state (FIRE_* in shot_pkg)
//   light_sense   in   zapper photodiode, asynchronous to clk
//   blank_screen  out  force the display black
//   draw_target   out  draw a white box at the duck position
//   hit           out  1-cycle pulse, duck hit
//   miss          out  1-cycle pulse, shot missed or duck escaped
//   escaped       out  1-cycle pulse, together with miss on timeout
//   cheat         out  1-cycle pulse, light seen during the blank frame
//   shells_left   out  3  shells remaining in the current round
//   leave         out  1-cycle pulse; clears the firing FSM
//   busy          out  high in every state except IDLE
//   dbg_state     out  3  current resolver state (shot_state_t encoding)
//
// Interface timing: round_start and fire_state are sampled on the rising
// edge. All outputs are registered. A shot sampled at edge N drives
// blank_screen during cycles N..N+F-1 and draw_target during N+F..N+2F-1.
// hit/miss/cheat/escaped and the new shells_left are registered at the edge
// that enters RESOLVE, and leave follows one cycle later.
// -----------------------------------------------------------------------------
module shot_resolver
    import shot_pkg::*;
#(
    parameter int SHELLS        = 3,
    parameter int FLASH_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int ESCAPE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       round_start,
    input  logic [1:0] fire_state,
    input  logic       light_sense,
    output logic       blank_screen,
    output logic       draw_target,
    output logic       hit,
    output logic       miss,
    output logic       escaped,
    output logic       cheat,
    output logic [2:0] shells_left,
    output logic       leave,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int FW = (FLASH_CYCLES  > 1) ? $clog2(FLASH_CYCLES)  : 1;
    localparam int EW = (ESCAPE_CYCLES > 1) ? $clog2(ESCAPE_CYCLES) : 1;

    localparam logic [FW-1:0] FRAME_LAST   = FW'(FLASH_CYCLES - 1);
    localparam logic [FW-1:0] SETTLE_FIRST = FW'(SETTLE_CYCLES);
    localparam logic [EW-1:0] ESCAPE_LAST  = EW'(ESCAPE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Light sensor synchroniser
    // -------------------------------------------------------------------------
    logic w_ls;

    sync_2ff #(
        .WIDTH (1)
    ) u_light_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (light_sense),
        .o_q     (w_ls)
    );

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    shot_state_t   r_state;
    logic [FW-1:0] r_frame_cnt;
    logic [EW-1:0] r_esc_cnt;
    logic          r_tl;          // light seen inside the target window so far
    logic          r_round_over;  // RESOLVE exits to LEAVE rather than ARMED
    logic [2:0]    r_shells;
    logic          r_blank;
    logic          r_draw;
    logic          r_hit;
    logic          r_miss;
    logic          r_escaped;
    logic          r_cheat;
    logic          r_leave;
    logic          r_busy;

    logic w_shot;
    logic w_frame_last;
    logic w_tl_final;
    logic w_cheat_block;
    logic w_hit;

    assign w_shot       = (fire_state == FIRE_SHOT);
    assign w_frame_last = (r_frame_cnt == FRAME_LAST);

    // The last target cycle is always inside the window (SETTLE < FLASH), so
    // its ls sample is merged in directly rather than waiting another cycle.
    assign w_tl_final = r_tl | w_ls;
    assign w_hit      = w_tl_final & ~w_cheat_block;

`ifdef SHOT_RESOLVER_CHEAT_DETECT_EN
    // Light on the final blank cycle means the zapper is aimed at something
    // other than the screen (a lamp, for example).
    logic r_bl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bl <= 1'b0;
        end else if (r_state == BLANK && w_frame_last) begin
            r_bl <= w_ls;
        end
    end

    assign w_cheat_block = r_bl;
`else
    assign w_cheat_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_frame_cnt  <= '0;
            r_esc_cnt    <= '0;
            r_tl         <= 1'b0;
            r_round_over <= 1'b0;
            r_shells     <= 3'd0;
            r_blank      <= 1'b0;
            r_draw       <= 1'b0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_escaped    <= 1'b0;
            r_cheat      <= 1'b0;
            r_leave      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Result outputs are single-cycle pulses unless set below.
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_escaped <= 1'b0;
            r_cheat   <= 1'b0;
            r_leave   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (round_start) begin
                        r_shells  <= 3'(SHELLS);
                        r_esc_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ARMED;
                    end
                end

                ARMED: begin
                    // A shot on the expiry cycle wins over the escape. The
                    // escape count holds while a shot is being resolved.
                    if (w_shot) begin
                        r_frame_cnt <= '0;
                        r_tl        <= 1'b0;
                        r_blank     <= 1'b1;
                        r_state     <= BLANK;
                    end else if (r_esc_cnt == ESCAPE_LAST) begin
                        r_miss       <= 1'b1;
                        r_escaped    <= 1'b1;
                        r_round_over <= 1'b1;
                        r_state      <= RESOLVE;
                    end else begin
                        r_esc_cnt <= r_esc_cnt + EW'(1);
                    end
                end

                BLANK: begin
                    if (w_frame_last) begin
                        r_frame_cnt <= '0;
                        r_blank     <= 1'b0;
                        r_draw      <= 1'b1;
                        r_state     <= TARGET;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + FW'(1);
                    end
                end

                TARGET: begin
                    if (w_frame_last) begin
                        r_draw       <= 1'b0;
                        r_hit        <= w_hit;
                        r_miss       <= ~w_hit;
                        r_cheat      <= w_cheat_block;
                        r_round_over <= w_hit | (r_shells <= 3'd1);
                        if (r_shells != 3'd0) begin
                            r_shells <= r_shells - 3'd1;
                        end
                        r_state      <= RESOLVE;
                    end else begin
                        // The display needs a few cycles to settle, so the
                        // first target cycles are not sampled.
                        if (r_frame_cnt >= SETTLE_FIRST) begin
                            r_tl <= r_tl | w_ls;
                        end
                        r_frame_cnt <= r_frame_cnt + FW'(1);
                    end
                end

                RESOLVE: begin
                    if (r_round_over) begin
                        r_leave <= 1'b1;
                        r_state <= LEAVE;
                    end else begin
                        r_state <= ARMED;
                    end
                end

                LEAVE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_blank <= 1'b0;
                    r_draw  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign blank_screen = r_blank;
    assign draw_target  = r_draw;
    assign hit          = r_hit;
    assign miss         = r_miss;
    assign escaped      = r_escaped;
    assign cheat        = r_cheat;
    assign shells_left  = r_shells;
    assign leave        = r_leave;
    assign busy         = r_busy;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_shot_resolver.sv
// -----------------------------------------------------------------------------
// tb_shot_resolver
//
// Directed bench for shot_resolver with SHELLS=3, FLASH_CYCLES=8,
// SETTLE_CYCLES=2, ESCAPE_CYCLES=64. Inputs change 1 ns after the rising
// edge, and outputs are read at the same point.
//
// Light timing: raw light_sense driven in cycle c reaches the resolver's ls in
// cycle c+2. For a shot sampled at edge N, cycle N+k has k=0..7 for the blank
// frame and k=8..15 for the target frame (target cycle j = k-8).
// -----------------------------------------------------------------------------
module tb_shot_resolver;
    import shot_pkg::*;

    localparam int SHELLS = 3;
    localparam int F      = 8;
    localparam int SETTLE = 2;
    localparam int ESC    = 64;

`ifdef SHOT_RESOLVER_CHEAT_DETECT_EN
    localparam logic CHEAT_EN = 1'b1;
`else
    localparam logic CHEAT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       round_start = 1'b0;
    logic [1:0] fire_state  = 2'b00;
    logic       light_sense = 1'b0;

    logic       blank_screen;
    logic       draw_target;
    logic       hit;
    logic       miss;
    logic       escaped;
    logic       cheat;
    logic [2:0] shells_left;
    logic       leave;
    logic       busy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    shot_resolver #(
        .SHELLS        (SHELLS),
        .FLASH_CYCLES  (F),
        .SETTLE_CYCLES (SETTLE),
        .ESCAPE_CYCLES (ESC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .round_start  (round_start),
        .fire_state   (fire_state),
        .light_sense  (light_sense),
        .blank_screen (blank_screen),
        .draw_target  (draw_target),
        .hit          (hit),
        .miss         (miss),
        .escaped      (escaped),
        .cheat        (cheat),
        .shells_left  (shells_left),
        .leave        (leave),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          both_cnt = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The two drive outputs must never overlap.
    always @(negedge clk) begin
        if (blank_screen && draw_target) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_round();
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
    endtask

    // Fires one shot (sampled at edge N) and drives raw light in cycles
    // N+lo..N+hi. It checks the frame timing and returns 1 ns after edge N+2F,
    // when the result pulses are visible.
    task automatic shot_seq(input int lo, input int hi);
        int bad = 0;
        fire_state = FIRE_SHOT;
        tick();
        fire_state = FIRE_RELOAD;
        for (int k = 0; k < 2 * F; k++) begin
            light_sense = (k >= lo && k <= hi);
            if (blank_screen !== (k < F))  bad++;
            if (draw_target  !== (k >= F)) bad++;
            if (hit || miss || leave)      bad++;
            tick();
        end
        light_sense = 1'b0;
        check("frame_timing", bad, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int bad;

        // Reset state
        #12;
        check("rst_blank",  blank_screen, 0);
        check("rst_draw",   draw_target,  0);
        check("rst_pulses", {hit, miss, escaped, cheat, leave}, 0);
        check("rst_shells", shells_left,  0);
        check("rst_busy",   busy,         0);
        check("rst_state",  dbg_state,    IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Hit: light in target cycles 4..7 -> hit at N+2F, leave, then idle
        start_round();
        check("hit_load_shells", shells_left, 3);
        check("hit_busy",        busy,        1);
        check("hit_armed",       dbg_state,   ARMED);
        fire_state = FIRE_HOLD;
        ticks(3);
        check("hold_ignored", dbg_state, ARMED);
        shot_seq(12, 15);
        check("hit_pulse",  hit,         1);
        check("hit_nomiss", miss,        0);
        check("hit_shells", shells_left, 2);
        check("hit_cheat",  cheat,       0);
        tick();
        check("hit_leave",      leave, 1);
        check("hit_pulse_end",  hit,   0);
        check("hit_busy_leave", busy,  1);
        tick();
        check("hit_busy_low", busy,      0);
        check("hit_idle",     dbg_state, IDLE);

        // Three misses: shells 2,1,0, leave only after the last one
        start_round();
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(0);
        for (int s = 0; s < 3; s++) begin
            ticks(2);
            shot_seq(99, 99);
            check("miss_pulse",  miss,        1);
            check("miss_nohit",  hit,         0);
            check("miss_shells", shells_left, exp_q.pop_front());
            tick();
            check("miss_leave",  leave,       (s == 2));
        end
        tick();
        check("miss_idle", busy, 0);
        // A fourth shot has no effect after the round has ended.
        fire_state = FIRE_SHOT;
        tick();
        fire_state = FIRE_RELOAD;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (blank_screen || draw_target || hit || miss || leave || busy) bad++;
            tick();
        end
        check("fourth_shot_ignored", bad,         0);
        check("fourth_shot_shells",  shells_left, 0);

        // Escape: 64 ARMED cycles with no shot
        start_round();
        bad = 0;
        for (int i = 0; i < ESC - 1; i++) begin
            tick();
            if (miss || escaped || leave) bad++;
        end
        check("esc_not_early", bad,       0);
        check("esc_armed",     dbg_state, ARMED);
        tick();
        check("esc_miss",    miss,        1);
        check("esc_escaped", escaped,     1);
        check("esc_shells",  shells_left, 3);
        tick();
        check("esc_leave",     leave,   1);
        check("esc_pulse_end", escaped, 0);
        tick();
        check("esc_idle", busy, 0);

        // A shot on the expiry cycle wins, and the escape count then resumes.
        start_round();
        ticks(ESC - 1);
        shot_seq(99, 99);
        check("prio_miss",    miss,        1);
        check("prio_noesc",   escaped,     0);
        check("prio_shells",  shells_left, 2);
        tick();
        check("prio_rearmed", dbg_state,   ARMED);
        check("prio_noleave", leave,       0);
        tick();
        check("resume_esc_miss",    miss,        1);
        check("resume_esc_escaped", escaped,     1);
        check("resume_esc_shells",  shells_left, 2);
        tick();
        check("resume_esc_leave", leave, 1);
        tick();

        // Settle window: ls high only in target cycles 0..1 -> miss.
        // Then ls high only in target cycle 2 (first counted cycle) -> hit.
        start_round();
        ticks(2);
        shot_seq(6, 7);
        check("settle_miss",  miss, 1);
        check("settle_nohit", hit,  0);
        tick();
        ticks(2);
        shot_seq(8, 8);
        check("settle_edge_hit", hit,         1);
        check("settle_shells",   shells_left, 1);
        tick();
        check("settle_leave", leave, 1);
        tick();

        // Light held high during the whole sequence
        start_round();
        ticks(2);
        shot_seq(0, 15);
        check("cheat_flag",   cheat,       CHEAT_EN);
        check("cheat_hit",    hit,         !CHEAT_EN);
        check("cheat_miss",   miss,        CHEAT_EN);
        check("cheat_shells", shells_left, 2);
        tick();
        check("cheat_leave",  leave,       !CHEAT_EN);
        ticks(2);

        // Async reset in the middle of TARGET
        if (dbg_state == IDLE) start_round();
        ticks(2);
        fire_state = FIRE_SHOT;
        tick();
        fire_state = FIRE_RELOAD;
        ticks(F + 1);
        check("rst_mid_draw_before", draw_target, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_draw",   draw_target,  0);
        check("rst_mid_blank",  blank_screen, 0);
        check("rst_mid_pulses", {hit, miss, escaped, cheat, leave}, 0);
        check("rst_mid_shells", shells_left,  0);
        check("rst_mid_busy",   busy,         0);
        check("rst_mid_state",  dbg_state,    IDLE);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (leave || busy) bad++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (leave || busy) bad++;
        end
        check("rst_mid_no_leave", bad, 0);
        start_round();
        check("rst_restart_shells", shells_left, 3);
        check("rst_restart_busy",   busy,        1);

        check("blank_draw_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
